// File: rtl/vga_frame_capture.sv
// vga_frame_capture: receive end of the VGA path. Samples 640x480@60 hsync/vsync/RGB444
// on the pixel clock and writes a 2:1 decimated 320x240 frame through the image RAM
// write port (wea/addra/dina). One-shot or continuous capture.
// Optional build macro: CAPTURE_TIMING_CHECK_EN enables line/frame length checking
// (sync_err); without it sync_err is tied low.
module vga_frame_capture #(
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        continuous,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [11:0] rgb_in,
  output logic        wea,
  output logic [16:0] addra,
  output logic [11:0] dina,
  output logic        busy,
  output logic        frame_done,
  output logic        sync_err
);

  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACT);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACT);
  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        hs_r, vs_r, hs_p, vs_p;
  logic [11:0] rgb_r;
  logic        hfall, vfall;
  logic [9:0]  h_cnt, v_cnt;
  logic [9:0]  h_act, v_act;
  logic        h_valid, v_valid, pixel_hit;
  logic [16:0] row, addr_nxt;
  logic        wr_en, frame_end, timing_err;

  // Input stage: register the raw inputs once, keep the previous sync levels for edge detection.
  // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_r  <= 1'b1;
      vs_r  <= 1'b1;
      hs_p  <= 1'b1;
      vs_p  <= 1'b1;
      rgb_r <= '0;
    end else begin
      hs_r  <= hsync_in;
      vs_r  <= vsync_in;
      hs_p  <= hs_r;
      vs_p  <= vs_r;
      rgb_r <= rgb_in;
    end
  end

  assign hfall = hs_p & ~hs_r;
  assign vfall = vs_p & ~vs_r;

  // Line and frame position counters; both saturate so a dead source cannot wrap into the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (hfall)                 h_cnt <= '0;
      else if (h_cnt != CNT_MAX) h_cnt <= h_cnt + 10'd1;

      if (vfall)                          v_cnt <= '0;
      else if (hfall && v_cnt != CNT_MAX) v_cnt <= v_cnt + 10'd1;
    end
  end

  assign h_act     = h_cnt - H_START;
  assign v_act     = v_cnt - V_START;
  assign h_valid   = (h_cnt >= H_START) && (h_cnt < H_END);
  assign v_valid   = (v_cnt >= V_START) && (v_cnt < V_END);
  assign pixel_hit = h_valid && v_valid && !h_act[0] && !v_act[0];

  // Decimated address: row*320 + column, with row*320 built as row*256 + row*64.
  assign row      = 17'(v_act[9:1]);
  assign addr_nxt = (row << 8) + (row << 6) + 17'(h_act[9:1]);

`ifdef CAPTURE_TIMING_CHECK_EN
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // The vfall that brings us into CAPTURE is seen in WAIT_VS, so it is never length-checked.
  assign timing_err = (state == CAPTURE) &&
                      ((hfall && (h_cnt != H_LAST)) || (vfall && (v_cnt != V_LAST)));

  // Sticky timing error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)             sync_err <= 1'b0;
    else if (timing_err) sync_err <= 1'b1;
  end
`else
  logic unused_timing;
  assign unused_timing = (H_TOTAL + V_TOTAL) > 0;
  assign timing_err    = 1'b0;
  assign sync_err      = 1'b0;
`endif

  // Capture state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, write qualification and end-of-frame detection.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      IDLE:    if (arm)   state_nxt = WAIT_VS;
      WAIT_VS: if (vfall) state_nxt = CAPTURE;
      CAPTURE: begin
        if (timing_err) begin
          state_nxt = IDLE;
        end else begin
          wr_en = pixel_hit;
          // A vfall before the frame completes restarts capture; counters clear on their own.
          if (!vfall && hfall && (v_cnt == V_END - 10'd1)) begin
            frame_end = 1'b1;
            state_nxt = (continuous || arm) ? WAIT_VS : IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // RAM write port and frame_done pulse, registered one cycle after the qualifying sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      frame_done <= 1'b0;
    end else begin
      wea        <= wr_en;
      frame_done <= frame_end;
      if (wr_en) begin
        addra <= addr_nxt;
        dina  <= rgb_r;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: directed sequence with randomized timing against a reference
// image model. Uses a scaled-down raster so many frames fit in a short run; the RAM
// row stride stays 320 as the design fixes it.
module tb_vga_frame_capture;

  localparam int H_SYNC  = 8;
  localparam int H_BP    = 6;
  localparam int H_ACT   = 40;
  localparam int H_TOTAL = 64;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 3;
  localparam int V_ACT   = 12;
  localparam int V_TOTAL = 20;

  localparam int COLS  = H_ACT / 2;
  localparam int ROWS  = V_ACT / 2;
  localparam int N_WR  = COLS * ROWS;
  localparam int FRAME = H_TOTAL * V_TOTAL;
  localparam int V_END = V_SYNC + V_BP + V_ACT;
  // The capture counter restarts one clock after the registered sync edge, so active
  // pixel x is the one driven at generator column H_SYNC+H_BP+1+x.
  localparam int X0 = H_SYNC + H_BP + 1;
  localparam int Y0 = V_SYNC + V_BP;

  logic        clk;
  logic        rst, arm, continuous;
  logic        hsync_in, vsync_in;
  logic [11:0] rgb_in;
  logic        wea, busy, frame_done, sync_err;
  logic [16:0] addra;
  logic [11:0] dina;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hg = 0, vg = 0;
  int short_line = -1;
  int last_hs_cyc = 0, frame_start_cyc = -1, vend_cyc = 0;
  int wr_idx = 0, wr_total = 0, done_count = 0, busy_low = 0;
  int done_cyc_q[$];
  logic [11:0] img [0:2047];

  vga_frame_capture #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_TOTAL(V_TOTAL)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .continuous(continuous),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
    .wea(wea), .addra(addra), .dina(dina),
    .busy(busy), .frame_done(frame_done), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference image: pixel colour is a function of its coordinates only.
  function automatic logic [11:0] pix(input int x, input int y);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    return {xv[3:0], yv[3:0], 4'hA};
  endfunction

  // The k-th write of a frame is decimated pixel k in raster order.
  function automatic logic [16:0] exp_addr(input int k);
    return 17'((k / COLS) * 320 + (k % COLS));
  endfunction

  function automatic logic [11:0] exp_data(input int k);
    return pix(2 * (k % COLS), 2 * (k / COLS));
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_count < target && n < budget) begin
      tick();
      n++;
    end
    check("done_count", done_count, target);
  endtask

  task automatic wait_frame_start(input int budget);
    int fs, n;
    fs = frame_start_cyc;
    n  = 0;
    while (frame_start_cyc == fs && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Cycle counter: number of rising edges so far.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Raster generator; a single line can be shortened by one clock via short_line.
  initial begin
    int len;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    rgb_in   = '0;
    forever begin
      @(negedge clk);
      hsync_in = (hg >= H_SYNC);
      vsync_in = (vg >= V_SYNC);
      rgb_in   = pix(hg - X0, vg - Y0);
      if (hg == 0) begin
        last_hs_cyc = cyc;
        if (vg == 0)     frame_start_cyc = cyc;
        if (vg == V_END) vend_cyc = cyc;
      end
      len = (vg == short_line) ? H_TOTAL - 1 : H_TOTAL;
      if (hg == len - 1) begin
        hg = 0;
        vg = (vg == V_TOTAL - 1) ? 0 : vg + 1;
      end else begin
        hg++;
      end
    end
  end

  // Write/frame monitor against the reference image.
  initial forever begin
    @(negedge clk);
    if (rst === 1'b1) wr_idx = 0;
    if (wea === 1'b1) begin
      check("wr_addr", addra, exp_addr(wr_idx));
      check("wr_data", dina, exp_data(wr_idx));
      if (addra < 17'd2048) img[addra[10:0]] = dina;
      wr_idx++;
      wr_total++;
    end
    if (frame_done === 1'b1) begin
      done_count++;
      done_cyc_q.push_back(cyc);
      check("done_latency", cyc - vend_cyc, 2);
      check("frame_writes", wr_idx, N_WR);
      wr_idx = 0;
    end
    if (busy !== 1'b1) busy_low++;
  end

  initial begin
    int base, d0, k, n, bl;
    rst = 1'b1; arm = 1'b0; continuous = 1'b0;

    // Reset held with the raster running.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_wea", wea, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_addra", addra, 0);
      check("rst_dina", dina, 0);
      check("rst_sync_err", sync_err, 0);
    end
    rst = 1'b0;
    wait_cycles(2 * FRAME);
    check("idle_writes", wr_total, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done_count, 0);

    // One-shot capture armed at a random point.
    wait_cycles($urandom_range(1, FRAME));
    pulse_arm();
    wait_done(1, 3 * FRAME);
    check("oneshot_writes", wr_total, N_WR);
    check("first_pixel", img[0], 12'h00A);
    check("pixel_2_2", img[321], 12'h22A);
    check("last_pixel", img[(ROWS - 1) * 320 + COLS - 1], pix(H_ACT - 2, V_ACT - 2));
    tick();
    check("oneshot_busy", busy, 0);
    wait_cycles(FRAME + 100);
    check("oneshot_no_rearm_writes", wr_total, N_WR);
    check("oneshot_no_rearm_done", done_count, 1);

    // Arm in the middle of the active region.
    n = 0;
    while (!(vg == 10 && hg == 20) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    base = wr_total;
    pulse_arm();
    wait_frame_start(2 * FRAME);
    check("midarm_no_writes", wr_total, base);
    check("midarm_busy", busy, 1);
    wait_done(2, 2 * FRAME);
    check("midarm_writes", wr_total, base + N_WR);

    // Continuous capture: three back-to-back frames, then drop continuous.
    base = wr_total;
    d0 = done_count;
    continuous = 1'b1;
    wait_cycles($urandom_range(1, FRAME));
    pulse_arm();
    wait_done(d0 + 1, 3 * FRAME);
    bl = busy_low;
    wait_done(d0 + 3, 3 * FRAME);
    check("cont_busy_low", busy_low - bl, 0);
    check("cont_spacing_1", done_cyc_q[d0 + 1] - done_cyc_q[d0], FRAME);
    check("cont_spacing_2", done_cyc_q[d0 + 2] - done_cyc_q[d0 + 1], FRAME);
    continuous = 1'b0;
    wait_done(d0 + 4, 2 * FRAME);
    tick();
    check("cont_stop_busy", busy, 0);
    check("cont_writes", wr_total, base + 4 * N_WR);

    // Reset in the middle of a capture.
    base = wr_total;
    d0 = done_count;
    k = $urandom_range(10, N_WR - 10);
    pulse_arm();
    n = 0;
    while (wr_total < base + k && n < 3 * FRAME) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_wea", wea, 0);
    check("rstmid_busy", busy, 0);
    wait_cycles(2 * FRAME);
    check("rstmid_writes", wr_total, base + k);
    check("rstmid_done", done_count, d0);
    pulse_arm();
    wait_done(d0 + 1, 3 * FRAME);
    check("rstmid_rearm_writes", wr_total, base + k + N_WR);

`ifdef CAPTURE_TIMING_CHECK_EN
    // One short line mid-frame must abort the capture and latch sync_err.
    check("err_clear", sync_err, 0);
    pulse_arm();
    wait_frame_start(2 * FRAME);
    short_line = 10;
    n = 0;
    while (sync_err !== 1'b1 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check("err_set", sync_err, 1);
    check("err_latency", cyc - last_hs_cyc, 2);
    short_line = -1;
    base = wr_total;
    d0 = done_count;
    wait_cycles(FRAME + 50);
    check("err_no_writes", wr_total, base);
    check("err_busy", busy, 0);
    check("err_no_done", done_count, d0);
    check("err_sticky", sync_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_reset", sync_err, 0);
`else
    check("no_sync_err", sync_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Receive end of the VGA display path: samples incoming 640x480@60 hsync/vsync/RGB444 and writes a 2:1 decimated 320x240 frame into the single-port 12-bit x 76800 block RAM image memory.
- Uses the same RAM write interface (wea/addra/dina) that the display path reads, so a captured frame displays unchanged.
- Inputs are synchronous to clk, which is the 25 MHz pixel clock.
- Supports one-shot and continuous capture.

Parameters:
- H_SYNC, 96, hsync pulse width in pixel clocks
- H_BP, 48, horizontal back porch
- H_ACT, 640, active pixels per line
- H_TOTAL, 800, pixel clocks per line
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
- V_ACT, 480, active lines per frame
- V_TOTAL, 525, lines per frame

Ports:
- clk  input  1  pixel clock (25 MHz); all logic on rising edge
- rst  input  1  synchronous, active-high reset
- arm  input  1  level/pulse; requests capture of the next full frame
- continuous  input  1  1 = re-arm automatically after each frame
- hsync_in  input  1  horizontal sync, active-low
- vsync_in  input  1  vertical sync, active-low
- rgb_in  input  12  {R[3:0],G[3:0],B[3:0]}
- wea  output  1  RAM write enable
- addra  output  17  RAM write address, 0..76799
- dina  output  12  RAM write data
- busy  output  1  high in WAIT_VS or CAPTURE
- frame_done  output  1  one-cycle pulse at end of a complete captured frame
- sync_err  output  1  sticky timing-error flag (optional feature only; otherwise 0)

Behaviour:
- Reset: wea=0, addra=0, dina=0, busy=0, frame_done=0, sync_err=0; state IDLE; h_cnt=0; v_cnt=0; all input registers reset to idle level (syncs=1, rgb=0).
- Input stage:
  - hsync_in, vsync_in and rgb_in are registered once (hs_r, vs_r, rgb_r); a second register holds previous hs_r and vs_r.
  - hfall = prev hs_r 1 and hs_r 0; vfall is defined the same way.
- h_cnt (10 bit): cleared to 0 on hfall, otherwise increments, saturating at 1023.
- v_cnt (10 bit): cleared on vfall (vfall has priority when vfall and hfall coincide); otherwise increments on hfall, saturating at 1023.
- Active window:
  - h_act = h_cnt - (H_SYNC+H_BP), valid when h_cnt is in [144,783].
  - v_act = v_cnt - (V_SYNC+V_BP), valid when v_cnt is in [35,514].
- Write condition: state CAPTURE, both window terms valid, h_act[0]=0 and v_act[0]=0.
- Write cycle: the cycle after the qualifying rgb_r sample, wea=1, dina=that sample, addra=(v_act>>1)*320 + (h_act>>1), computed as shift-add (x256 + x64). Latency from rgb_in to dina is 2 clocks.
- wea is high for exactly one cycle per written pixel: 320 writes per even active line, 76800 per frame.
- States:
  - IDLE: busy=0. On arm=1 go to WAIT_VS.
  - WAIT_VS: no writes. On vfall go to CAPTURE; the counters are cleared that same cycle.
  - CAPTURE:
    - On the hfall that makes v_cnt=515: pulse frame_done the next cycle. Go to WAIT_VS if continuous=1 or arm=1, else IDLE.
    - On vfall before v_cnt reaches 515 (truncated frame): no frame_done. Restart CAPTURE with the new frame; already written addresses are simply overwritten.
- arm during WAIT_VS or CAPTURE is ignored, except as re-arm at frame end.
- Reset mid-capture: wea deasserts the cycle after rst is sampled high; no further writes until a new arm.

Optional Feature:
- Macro: CAPTURE_TIMING_CHECK_EN.
- Defined:
  - In CAPTURE, every hfall checks that the previous line length (h_cnt+1) equals H_TOTAL.
  - Every vfall checks that the previous frame length (v_cnt+1) equals V_TOTAL. The first vfall after entering CAPTURE from WAIT_VS is exempt.
  - On any mismatch: sync_err is set (sticky until rst), wea is forced low immediately, state goes to IDLE, and no frame_done is issued.
- Not defined: no checks; sync_err is tied 0.

Test Plan:
- Reset behaviour: hold rst 5 cycles with a running timing source -> wea, busy, frame_done, addra and dina all 0 throughout; state stays IDLE afterwards without arm.
- Single frame, one-shot: bench timing generator drives rgb = {h[3:0], v[3:0], 4'hA}; arm pulsed 1 cycle, continuous=0 ->
  - exactly 76800 writes
  - first write addr 0 with data 12'h00A
  - write at addr 321 carries pixel (2,2) = 12'h22A
  - last write addr 76799 carries pixel (638,478) = 12'hEEA
  - one frame_done pulse, then busy=0
- Arm mid-frame: arm asserted at v_cnt=200 -> zero writes until the next vsync falling edge; then a full 76800-write frame.
- Continuous mode: continuous=1 for 3 frames -> three frame_done pulses spaced exactly 420000 cycles apart; busy stays 1.
- Reset mid-capture: rst asserted for 1 cycle at write #1000 -> wea=0 from the next cycle; no writes afterwards until arm; frame_done never pulses.
- With CAPTURE_TIMING_CHECK_EN: one 799-clock line injected at line 100 -> sync_err=1 at that hfall+1; wea=0 thereafter; state IDLE; sync_err persists until rst.
